// File: rtl/cb_cfg_pkg.sv
// Shared types and constants for the connection-block config loader.
// Combinational helpers only; no latency or flow control of its own.
package cb_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        STROBE,
        CHECK,
        DONE
    } cb_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam int MAX_BANKS = 16;

    // One nibble per bank, bank 0 in the low nibble: bank1 holds 2 bits, the rest 6.
    localparam logic [43:0] DEF_BANK_BITS = 44'h666_6666_6626;

    function automatic int total_bits(input logic [4*MAX_BANKS-1:0] bank_bits,
                                      input int num_banks);
        int sum;
        sum = 0;
        for (int b = 0; b < MAX_BANKS; b++) begin
            if (b < num_banks) sum += int'(bank_bits[4*b +: 4]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/cb_cfg_crc16.sv
// Serial CRC-16-CCITT step, one input bit per call, MSB-first shift.
// Purely combinational (zero latency); no flow control.
module cb_cfg_crc16
    import cb_cfg_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    always_comb begin
        crc_o = {crc_i[14:0], 1'b0};
        if (crc_i[15] ^ bit_i) crc_o = crc_o ^ CRC16_POLY;
    end

endmodule

// File: rtl/cb_config_loader.sv
// Unpacks a bitstream into per-bit CB config writes; 2 cycles per bit plus 1 per fetched word.
// Stalls in FETCH until bs_valid; optional trailer CRC check under CB_LOADER_CRC_EN.
module cb_config_loader
    import cb_cfg_pkg::*;
#(
    parameter int                     DATA_W    = 16,
    parameter int                     LO_W      = 3,
    parameter int                     HI_W      = 4,
    parameter int                     NUM_BANKS = 11,
    parameter logic [4*NUM_BANKS-1:0] BANK_BITS = DEF_BANK_BITS
) (
    input  logic                 prog_clk,
    input  logic                 prog_rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 bs_valid,
    output logic                 bs_ready,
    input  logic [DATA_W-1:0]    bs_data,
    output logic                 enable,
    output logic [LO_W+HI_W-1:0] address,
    output logic                 data_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int WB_W   = $clog2(DATA_W);
    localparam int ADDR_W = LO_W + HI_W;
    localparam int BB_W   = 4 * (2 ** HI_W);

    // Zero-padded so any bank_q value indexes a defined nibble.
    localparam logic [BB_W-1:0] BB_PAD = BB_W'(BANK_BITS);

    cb_state_e           state_q, state_d;
    logic [HI_W-1:0]     bank_q, bank_d;
    logic [LO_W-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [WB_W-1:0]     wbit_q, wbit_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                data_q, data_d;
    logic                err_q, err_d;

    logic [3:0]          bank_len;
    logic [3:0]          bit_inc;
    logic                last_bit;
    logic                last_loc;
    logic                last_wbit;

`ifdef CB_LOADER_CRC_EN
    logic [15:0]         crc_q, crc_d, crc_upd;
    logic                trl_q, trl_d;

    cb_cfg_crc16 u_crc (
        .crc_i (crc_q),
        .bit_i (data_q),
        .crc_o (crc_upd)
    );
`endif

    always_comb begin
        bank_len  = BB_PAD[4*int'(bank_q) +: 4];
        bit_inc   = 4'(bit_q) + 4'd1;
        last_bit  = (bit_inc == bank_len);
        last_loc  = last_bit && (bank_q == HI_W'(NUM_BANKS - 1));
        last_wbit = (wbit_q == WB_W'(DATA_W - 1));
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            wbit_q  <= '0;
            addr_q  <= '0;
            data_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef CB_LOADER_CRC_EN
            crc_q   <= CRC16_INIT;
            trl_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            wbit_q  <= wbit_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef CB_LOADER_CRC_EN
            crc_q   <= crc_d;
            trl_q   <= trl_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        bit_d   = bit_q;
        word_d  = word_q;
        wbit_d  = wbit_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef CB_LOADER_CRC_EN
        crc_d   = crc_q;
        trl_d   = trl_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    err_d   = 1'b0;
                    bank_d  = '0;
                    bit_d   = '0;
                    wbit_d  = '0;
`ifdef CB_LOADER_CRC_EN
                    crc_d   = CRC16_INIT;
                    trl_d   = 1'b0;
`endif
                end
            end
            FETCH: begin
                if (bs_valid) begin
                    word_d  = bs_data;
                    wbit_d  = '0;
                    state_d = SETUP;
`ifdef CB_LOADER_CRC_EN
                    if (trl_q) state_d = CHECK;
`endif
                end
            end
            SETUP: state_d = STROBE;
            STROBE: begin
`ifdef CB_LOADER_CRC_EN
                crc_d = crc_upd;
`endif
                if (last_bit) begin
                    bit_d  = '0;
                    bank_d = bank_q + 1'b1;
                end else begin
                    bit_d  = LO_W'(bit_inc);
                end
                if (last_loc) begin
`ifdef CB_LOADER_CRC_EN
                    state_d = FETCH;
                    trl_d   = 1'b1;
`else
                    state_d = DONE;
`endif
                end else if (last_wbit) begin
                    state_d = FETCH;
                end else begin
                    wbit_d  = wbit_q + 1'b1;
                    state_d = SETUP;
                end
            end
            CHECK: begin
`ifdef CB_LOADER_CRC_EN
                if (word_q[15:0] != crc_q) err_d = 1'b1;
`endif
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Address/data are captured on entry to SETUP so they hold steady across FETCH.
        if (state_d == SETUP) begin
            addr_d = {bank_d, bit_d};
            data_d = word_d[wbit_d];
        end

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            addr_d  = '0;
            data_d  = 1'b0;
            word_d  = word_q;
        end
    end

    always_comb begin
        bs_ready = (state_q == FETCH);
        enable   = (state_q == STROBE);
        busy     = (state_q != IDLE) && (state_q != DONE);
        done     = (state_q == DONE);
        address  = addr_q;
        data_in  = data_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_cb_config_loader.sv
// Bench for cb_config_loader: table of full loads plus abort, reset and busy-start sequences.
module tb_cb_config_loader;

    localparam int TOTAL = 62;
`ifdef CB_LOADER_CRC_EN
    localparam int CRC_EXTRA = 2;
`else
    localparam int CRC_EXTRA = 0;
`endif

    logic        prog_clk   = 1'b0;
    logic        prog_rst_n = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic        bs_valid   = 1'b0;
    logic        bs_ready;
    logic [15:0] bs_data    = 16'h0;
    logic        enable;
    logic [6:0]  address;
    logic        data_in;
    logic        busy;
    logic        done;
    logic        err;

    cb_config_loader #(
        .DATA_W    (16),
        .LO_W      (3),
        .HI_W      (4),
        .NUM_BANKS (11)
    ) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .start      (start),
        .abort      (abort),
        .bs_valid   (bs_valid),
        .bs_ready   (bs_ready),
        .bs_data    (bs_data),
        .enable     (enable),
        .address    (address),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct packed {
        logic [6:0] addr;
        logic       dat;
    } wr_t;

    typedef struct {
        logic [3:0][15:0] w;
        bit               bp;
        int               done_cyc;
        bit               crc_flip;
        bit               exp_err;
    } vec_t;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    bit          bp_mode  = 1'b0;
    int          bank_len [11] = '{6, 2, 6, 6, 6, 6, 6, 6, 6, 6, 6};
    wr_t         exp_q [$];
    logic [15:0] feed_q [$];
    wr_t         mon_got;

    always @(posedge prog_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Expected write stream and CRC for a 4-word load, bits taken LSB first.
    task automatic push_expected(input logic [3:0][15:0] w, output logic [15:0] crc);
        int   n;
        logic b;
        logic fb;
        n   = 0;
        crc = 16'hFFFF;
        for (int bk = 0; bk < 11; bk++) begin
            for (int i = 0; i < bank_len[bk]; i++) begin
                b = w[n/16][n%16];
                exp_q.push_back('{addr: 7'(bk*8 + i), dat: b});
                fb  = crc[15] ^ b;
                crc = {crc[14:0], 1'b0};
                if (fb) crc = crc ^ 16'h1021;
                n++;
            end
        end
    endtask

    task automatic queue_words(input vec_t v);
        logic [15:0] crc;
        push_expected(v.w, crc);
        for (int i = 0; i < 4; i++) feed_q.push_back(v.w[i]);
`ifdef CB_LOADER_CRC_EN
        feed_q.push_back(crc ^ {15'd0, v.crc_flip});
`endif
    endtask

    initial begin : feeder
        bit gate;
        int ph;
        bit hs_pend;
        gate    = 1'b1;
        ph      = 0;
        hs_pend = 1'b0;
        forever begin
            @(negedge prog_clk);
            if (hs_pend && feed_q.size() > 0) void'(feed_q.pop_front());
            if (bp_mode) begin
                ph++;
                if (ph == 3) begin
                    ph   = 0;
                    gate = ~gate;
                end
            end else begin
                gate = 1'b1;
            end
            bs_valid = gate && (feed_q.size() > 0);
            bs_data  = (feed_q.size() > 0) ? feed_q[0] : 16'h0;
            #2;
            hs_pend = bs_valid && bs_ready && !abort && prog_rst_n;
        end
    end

    always @(negedge prog_clk) begin
        if (enable) begin
            wr_cnt++;
            check("wr_not_in_fetch", bs_ready, 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data %0d, expected no write", address, data_in);
            end else begin
                mon_got = exp_q.pop_front();
                check("wr_addr", address, mon_got.addr);
                check("wr_data", data_in, mon_got.dat);
            end
        end
        if (done) done_cnt++;
    end

    task automatic pulse_start();
        @(negedge prog_clk);
        #1 start = 1'b1;
        @(negedge prog_clk);
        #1 start = 1'b0;
    endtask

    task automatic run_load(input vec_t v, input bit extra_start);
        int s;
        int base;
        int got_cyc;
        bit seen;
        base = wr_cnt;
        queue_words(v);
        bp_mode = v.bp;
        @(negedge prog_clk);
        #1 start = 1'b1;
        s = cyc;
        @(negedge prog_clk);
        #1 start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
        seen    = 1'b0;
        got_cyc = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge prog_clk);
            #1;
            start = extra_start && (wr_cnt - base == 30);
            if (done) begin
                seen    = 1'b1;
                got_cyc = cyc - s;
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        if (v.done_cyc > 0) check("done_cycle", got_cyc, v.done_cyc + CRC_EXTRA);
        check("busy_at_done", busy, 0);
        check("err_at_done", err, v.exp_err);
        check("write_count", wr_cnt - base, TOTAL);
        check("scoreboard_drained", exp_q.size(), 0);
        @(negedge prog_clk);
        #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        bp_mode = 1'b0;
    endtask

    task automatic abort_test(input vec_t v);
        int base;
        int dc;
        bit hit;
        base = wr_cnt;
        dc   = done_cnt;
        queue_words(v);
        pulse_start();
        hit = 1'b0;
        for (int k = 0; k < 500 && !hit; k++) begin
            @(negedge prog_clk);
            #1;
            if (enable && (wr_cnt - base == 21)) hit = 1'b1;
        end
        check("abort_reached_bit20", hit, 1);
        abort = 1'b1;
        @(negedge prog_clk);
        #1 abort = 1'b0;
        check("abort_enable", enable, 0);
        check("abort_address", address, 0);
        check("abort_err", err, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        exp_q.delete();
        feed_q.delete();
        repeat (10) @(negedge prog_clk);
        #1;
        check("abort_err_sticky", err, 1);
        check("abort_write_count", wr_cnt - base, 21);
        check("abort_no_done", done_cnt - dc, 0);
    endtask

    task automatic reset_test(input vec_t v);
        int base;
        bit hit;
        base = wr_cnt;
        queue_words(v);
        pulse_start();
        hit = 1'b0;
        for (int k = 0; k < 500 && !hit; k++) begin
            @(negedge prog_clk);
            #1;
            if ((wr_cnt - base >= 10) && busy && !enable && !bs_ready) hit = 1'b1;
        end
        check("reset_reached_setup", hit, 1);
        #1 prog_rst_n = 1'b0;
        #1;
        check("rst_enable", enable, 0);
        check("rst_address", address, 0);
        check("rst_data_in", data_in, 0);
        check("rst_bs_ready", bs_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        exp_q.delete();
        feed_q.delete();
        @(negedge prog_clk);
        #1 prog_rst_n = 1'b1;
        base = wr_cnt;
        repeat (20) @(negedge prog_clk);
        #1;
        check("rst_no_writes", wr_cnt - base, 0);
        check("rst_idle_busy", busy, 0);
        check("rst_idle_ready", bs_ready, 0);
    endtask

    initial begin : main
        vec_t tbl [$];
        int   base;

        tbl.push_back('{w: {16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF}, bp: 1'b0, done_cyc: 129, crc_flip: 1'b0, exp_err: 1'b0});
        tbl.push_back('{w: {16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF}, bp: 1'b1, done_cyc: 0,   crc_flip: 1'b0, exp_err: 1'b0});
        tbl.push_back('{w: {16'hC3A5, 16'h0F0F, 16'hABCD, 16'h1234}, bp: 1'b0, done_cyc: 129, crc_flip: 1'b0, exp_err: 1'b0});
        tbl.push_back('{w: {16'h8001, 16'h7FFE, 16'hDEAD, 16'hBEEF}, bp: 1'b1, done_cyc: 0,   crc_flip: 1'b0, exp_err: 1'b0});
`ifdef CB_LOADER_CRC_EN
        tbl.push_back('{w: {16'hC3A5, 16'h0F0F, 16'hABCD, 16'h1234}, bp: 1'b0, done_cyc: 129, crc_flip: 1'b1, exp_err: 1'b1});
`endif

        repeat (3) @(negedge prog_clk);
        #1;
        check("reset_enable", enable, 0);
        check("reset_address", address, 0);
        check("reset_data_in", data_in, 0);
        check("reset_bs_ready", bs_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        prog_rst_n = 1'b1;
        repeat (2) @(negedge prog_clk);

        for (int i = 0; i < tbl.size(); i++) run_load(tbl[i], 1'b0);

        // start pulsed mid-load must not restart or extend the walk
        run_load(tbl[2], 1'b1);

        // bs_valid held while idle: nothing may be consumed
        base = wr_cnt;
        feed_q.push_back(16'hFFFF);
        for (int k = 0; k < 6; k++) begin
            @(negedge prog_clk);
            #1;
            check("idle_ready_low", bs_ready, 0);
        end
        check("idle_word_kept", feed_q.size(), 1);
        check("idle_no_writes", wr_cnt - base, 0);
        feed_q.delete();
        repeat (2) @(negedge prog_clk);

        abort_test(tbl[0]);
        run_load(tbl[0], 1'b0);

        reset_test(tbl[2]);
        run_load(tbl[3], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
